// File: rtl/pcileech_rx_pkg.sv
// Shared definitions for the FT601 receive-stream unpacker: default framing
// constants, control-word type encodings and the unpacker FSM state type.
package pcileech_rx_pkg;

   localparam logic [31:0] FILLER_WORD_DEF = 32'h66665555;
   localparam logic [7:0]  CTRL_MAGIC_DEF  = 8'h77;

   localparam logic [1:0] TYPE_TLP      = 2'b00;
   localparam logic [1:0] TYPE_TLP_LAST = 2'b01;
   localparam logic [1:0] TYPE_CFG      = 2'b10;
   localparam logic [1:0] TYPE_CMD      = 2'b11;

   typedef enum logic {
      WAIT_DATA = 1'b0,
      WAIT_CTRL = 1'b1
   } rx_state_t;

endpackage

// File: rtl/pcileech_rx_unpack_if.sv
// Bus bundle between the FT601 receive side and the unpacker's TLP/config/
// command/status outputs. slave = unpacker view, master = driver/observer view.
interface pcileech_rx_unpack_if #(
   parameter int ERRCNT_W = 16
);
   logic [31:0]         ft601_rx_data;
   logic                ft601_rx_wren;
   logic [31:0]         pcie_tlp_tx_data;
   logic                pcie_tlp_tx_last;
   logic                pcie_tlp_tx_valid;
   logic [63:0]         pcie_cfg_tx_data;
   logic                pcie_cfg_tx_valid;
   logic [63:0]         cmd_data;
   logic                cmd_valid;
   logic [ERRCNT_W-1:0] err_count;
   logic                sync_lost;

   modport slave (
      input  ft601_rx_data, ft601_rx_wren,
      output pcie_tlp_tx_data, pcie_tlp_tx_last, pcie_tlp_tx_valid,
      output pcie_cfg_tx_data, pcie_cfg_tx_valid, cmd_data, cmd_valid,
      output err_count, sync_lost
   );

   modport master (
      output ft601_rx_data, ft601_rx_wren,
      input  pcie_tlp_tx_data, pcie_tlp_tx_last, pcie_tlp_tx_valid,
      input  pcie_cfg_tx_data, pcie_cfg_tx_valid, cmd_data, cmd_valid,
      input  err_count, sync_lost
   );
endinterface

// File: rtl/pcileech_rx_unpack.sv
// Splits the FT601 DWORD stream into {data, control} pairs and routes them to TLP,
// config or command outputs. Define PCILEECH_RX_ERRCNT_EN to build err_count/sync_lost.
module pcileech_rx_unpack
   import pcileech_rx_pkg::*;
#(
   parameter logic [31:0] FILLER_WORD = FILLER_WORD_DEF,
   parameter logic [7:0]  CTRL_MAGIC  = CTRL_MAGIC_DEF,
   parameter int          ERRCNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   pcileech_rx_unpack_if.slave bus
);

   rx_state_t   state_q, state_d;
   logic [31:0] hold_p0, hold_d;
   logic        word_ok, magic_ok;
   logic [1:0]  ctrl_type;
   logic        emit_tlp, emit_last, emit_cfg, emit_cmd;

   logic [31:0] tlp_data_p1;
   logic        tlp_last_p1, vld_tlp_p1;
   logic [63:0] cfg_data_p1, cmd_data_p1;
   logic        vld_cfg_p1, vld_cmd_p1;

   assign word_ok   = bus.ft601_rx_wren && (bus.ft601_rx_data != FILLER_WORD);
   assign magic_ok  = (bus.ft601_rx_data[31:24] == CTRL_MAGIC);
   assign ctrl_type = bus.ft601_rx_data[17:16];

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_p0;
      emit_tlp  = 1'b0;
      emit_last = 1'b0;
      emit_cfg  = 1'b0;
      emit_cmd  = 1'b0;
      if (word_ok) begin
         case (state_q)
            WAIT_DATA: begin
               hold_d  = bus.ft601_rx_data;
               state_d = WAIT_CTRL;
            end
            WAIT_CTRL: begin
               if (magic_ok) begin
                  state_d = WAIT_DATA;
                  case (ctrl_type)
                     TYPE_TLP:      emit_tlp = 1'b1;
                     TYPE_TLP_LAST: begin
                        emit_tlp  = 1'b1;
                        emit_last = 1'b1;
                     end
                     TYPE_CFG:      emit_cfg = 1'b1;
                     default:       emit_cmd = 1'b1;
                  endcase
               end else begin
                  // Slide by one DWORD: the bad control word may be the real data word.
                  hold_d = bus.ft601_rx_data;
               end
            end
            default: state_d = WAIT_DATA;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_DATA;
         hold_p0 <= '0;
      end else begin
         state_q <= state_d;
         hold_p0 <= hold_d;
      end
   end

   // Output register stage: strobes for one cycle, data holds between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tlp_data_p1 <= '0;
         tlp_last_p1 <= 1'b0;
         vld_tlp_p1  <= 1'b0;
         cfg_data_p1 <= '0;
         vld_cfg_p1  <= 1'b0;
         cmd_data_p1 <= '0;
         vld_cmd_p1  <= 1'b0;
      end else begin
         vld_tlp_p1 <= emit_tlp;
         vld_cfg_p1 <= emit_cfg;
         vld_cmd_p1 <= emit_cmd;
         if (emit_tlp) begin
            tlp_data_p1 <= hold_p0;
            tlp_last_p1 <= emit_last;
         end
         if (emit_cfg) cfg_data_p1 <= {bus.ft601_rx_data, hold_p0};
         if (emit_cmd) cmd_data_p1 <= {bus.ft601_rx_data, hold_p0};
      end
   end

   assign bus.pcie_tlp_tx_data  = tlp_data_p1;
   assign bus.pcie_tlp_tx_last  = tlp_last_p1;
   assign bus.pcie_tlp_tx_valid = vld_tlp_p1;
   assign bus.pcie_cfg_tx_data  = cfg_data_p1;
   assign bus.pcie_cfg_tx_valid = vld_cfg_p1;
   assign bus.cmd_data          = cmd_data_p1;
   assign bus.cmd_valid         = vld_cmd_p1;

`ifdef PCILEECH_RX_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_count_p1;
   logic                sync_lost_p1;
   logic                bad_ctrl, emit_any;

   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
      return (&v) ? v : v + ERRCNT_W'(1);
   endfunction

   assign bad_ctrl = word_ok && (state_q == WAIT_CTRL) && !magic_ok;
   assign emit_any = emit_tlp || emit_cfg || emit_cmd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_p1 <= '0;
         sync_lost_p1 <= 1'b0;
      end else if (bad_ctrl) begin
         err_count_p1 <= sat_inc(err_count_p1);
         sync_lost_p1 <= 1'b1;
      end else if (emit_any) begin
         sync_lost_p1 <= 1'b0;
      end
   end

   assign bus.err_count = err_count_p1;
   assign bus.sync_lost = sync_lost_p1;
`else
   assign bus.err_count = {ERRCNT_W{1'b0}};
   assign bus.sync_lost = 1'b0;
`endif

endmodule

// File: tb/tb_pcileech_rx_unpack.sv
// Scoreboard bench for pcileech_rx_unpack: directed pairs push expected outputs,
// a negedge monitor pops and compares whatever the DUT strobes.
module tb_pcileech_rx_unpack;

   localparam int ERRCNT_W = 16;
`ifdef PCILEECH_RX_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      int          kind;   // 0 TLP, 1 CFG, 2 CMD
      logic [63:0] data;
      logic        last;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   pcileech_rx_unpack_if #(.ERRCNT_W(ERRCNT_W)) bus ();

   pcileech_rx_unpack #(.ERRCNT_W(ERRCNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic send(input logic [31:0] w);
      @(negedge clk);
      bus.ft601_rx_wren = 1'b1;
      bus.ft601_rx_data = w;
   endtask

   task automatic send_exp(input logic [31:0] w, input int kind, input logic [63:0] d,
                           input logic last);
      exp_t e;
      send(w);
      e.kind = kind;
      e.data = d;
      e.last = last;
      e.due  = cyc + 1;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.ft601_rx_wren = 1'b0;
         bus.ft601_rx_data = 32'h0;
      end
   endtask

   task automatic chk_status(input string name, input logic [15:0] err, input logic sl);
      chk({name, "_err"}, 64'(bus.err_count), ERR_EN ? 64'(err) : 64'd0);
      chk({name, "_sync"}, 64'(bus.sync_lost), ERR_EN ? 64'(sl) : 64'd0);
   endtask

   // Monitor: every strobe must match the oldest expected pair, on its due cycle.
   always @(negedge clk) begin
      int   nv;
      int   kind;
      exp_t e;
      logic [63:0] d;
      logic l;
      nv = int'(bus.pcie_tlp_tx_valid) + int'(bus.pcie_cfg_tx_valid) + int'(bus.cmd_valid);
      if (nv > 1) chk("onehot_strobes", 64'(nv), 64'd1);
      if (nv != 0) begin
         kind = bus.pcie_tlp_tx_valid ? 0 : (bus.pcie_cfg_tx_valid ? 1 : 2);
         d = (kind == 0) ? {32'h0, bus.pcie_tlp_tx_data}
           : (kind == 1) ? bus.pcie_cfg_tx_data : bus.cmd_data;
         l = (kind == 0) ? bus.pcie_tlp_tx_last : 1'b0;
         if (sb_q.size() == 0) begin
            chk("unexpected_output", d, 64'hx);
         end else begin
            e = sb_q.pop_front();
            chk("out_kind", 64'(kind), 64'(e.kind));
            chk("out_data", d, e.data);
            chk("out_last", 64'(l), 64'(e.last));
            chk("out_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   initial begin
      bus.ft601_rx_wren = 1'b0;
      bus.ft601_rx_data = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_tlp_valid", 64'(bus.pcie_tlp_tx_valid), 64'd0);
      chk("rst_cfg_valid", 64'(bus.pcie_cfg_tx_valid), 64'd0);
      chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
      chk("rst_tlp_data", 64'(bus.pcie_tlp_tx_data), 64'd0);
      chk("rst_cfg_data", bus.pcie_cfg_tx_data, 64'd0);
      chk("rst_cmd_data", bus.cmd_data, 64'd0);
      chk_status("rst", 16'd0, 1'b0);
      rst_n = 1'b1;

      // Plain TLP pair
      send(32'h12345678);
      send_exp(32'h77000000, 0, 64'h12345678, 1'b0);
      idle(2);

      // Leading fillers then a config pair
      repeat (5) send(32'h66665555);
      send(32'hAABBCCDD);
      send_exp(32'h77020000, 1, 64'h77020000_AABBCCDD, 1'b0);
      idle(2);
      chk_status("cfg", 16'd0, 1'b0);

      // Gap and filler between data and control; last-TLP type with low bits set
      send(32'hCAFE0001);
      idle(3);
      send(32'h66665555);
      send_exp(32'h7701FFFF, 0, 64'hCAFE0001, 1'b1);
      idle(2);

      // Bad control word slides the pair, then a command
      send(32'h00000001);
      send(32'h00000002);
      idle(1);
      chk_status("bad_ctrl", 16'd1, 1'b1);
      send_exp(32'h77030000, 2, 64'h77030000_00000002, 1'b0);
      idle(1);
      chk_status("resync", 16'd1, 1'b0);
      idle(1);

      // Reset mid-pair discards the held data word
      send(32'h00000005);
      @(negedge clk);
      bus.ft601_rx_wren = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_status("async_rst", 16'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      send(32'h00000009);
      send_exp(32'h77010000, 0, 64'h9, 1'b1);
      idle(2);

      // Error counter saturation
      send(32'h00000001);
      for (int i = 1; i <= 70000; i++) begin
         send(32'h00000000);
         if (i == 1000) begin
            idle(1);
            chk_status("err_mid", 16'd1000, 1'b1);
         end
      end
      idle(1);
      chk_status("err_sat", 16'hFFFF, 1'b1);
      send_exp(32'h77000000, 0, 64'h0, 1'b0);
      idle(1);
      chk_status("err_hold", 16'hFFFF, 1'b0);

      idle(4);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcileech_rx_unpack.md
PCILEECH_RX_UNPACK -- requirements
Module: pcileech_rx_unpack

Interface
REQ-001 SHALL have parameter FILLER_WORD, default 32'h66665555: DWORD value discarded from the received stream.
REQ-002 SHALL have parameter CTRL_MAGIC, default 8'h77: required value of control DWORD bits [31:24].
REQ-003 SHALL have parameter ERRCNT_W, default 16: width of the error counter.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk and rst_n.
REQ-005 SHALL have port clk  in  1  system clock, 100 MHz.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port ft601_rx_data  in  32  DWORD received from the FT601 controller.
REQ-008 SHALL have port ft601_rx_wren  in  1  ft601_rx_data valid this cycle; cannot be throttled.
REQ-009 SHALL have port pcie_tlp_tx_data  out  32  TLP DWORD.
REQ-010 SHALL have port pcie_tlp_tx_last  out  1  final DWORD of the TLP.
REQ-011 SHALL have port pcie_tlp_tx_valid  out  1  single-cycle TLP DWORD strobe.
REQ-012 SHALL have port pcie_cfg_tx_data  out  64  {control, data} config request.
REQ-013 SHALL have port pcie_cfg_tx_valid  out  1  single-cycle config strobe.
REQ-014 SHALL have port cmd_data  out  64  {control, data} core command.
REQ-015 SHALL have port cmd_valid  out  1  single-cycle command strobe.
REQ-016 SHALL have port err_count  out  ERRCNT_W  saturating count of framing errors.
REQ-017 SHALL have port sync_lost  out  1  high from a framing error until the next good pair.

Function
REQ-018 SHALL carry the stream as pairs: data DWORD first, then control DWORD (bits [31:24] = CTRL_MAGIC, bits [17:16] = type: 00 TLP, 01 TLP-last, 10 CFG, 11 CMD).
REQ-019 SHALL discard any accepted DWORD equal to FILLER_WORD in either state, without changing state.
REQ-020 SHALL implement FSM states WAIT_DATA and WAIT_CTRL; a non-filler word in WAIT_DATA is latched and the FSM moves to WAIT_CTRL.
REQ-021 SHALL, in WAIT_CTRL on a word with a magic match, emit the pair per type and return to WAIT_DATA.
REQ-022 SHALL, in WAIT_CTRL on a magic mismatch, drop the held data, latch the current word as the new data, stay in WAIT_CTRL, increment err_count, and set sync_lost (one-DWORD slide resync).
REQ-023 SHALL register all outputs, with the valid strobe high exactly one cycle, on the cycle after the control-word wren.
REQ-024 SHALL drive tlp_last = 1 only for type 01; data ports hold their last value when the strobe is low.
REQ-025 SHALL assert at most one of the three valid strobes per cycle.
REQ-026 SHALL saturate err_count at all-ones, with no wrap.
REQ-027 SHALL clear sync_lost on the cycle a good pair is emitted.
REQ-028 SHALL keep its state when ft601_rx_wren is low, with no timeout.

Reset
REQ-029 SHALL, on assertion of rst_n, immediately (asynchronously) force state WAIT_DATA, all valid strobes 0, data ports 0, err_count 0, and sync_lost 0.
REQ-030 SHALL discard any partially received pair on reset mid-pair; the first word after deassertion is treated as data.

Configuration
REQ-031 SHALL include the err_count and sync_lost logic when PCILEECH_RX_ERRCNT_EN is defined.
REQ-032 SHALL, when PCILEECH_RX_ERRCNT_EN is not defined, tie err_count and sync_lost to 0; resync behaviour is unchanged.

Structure
REQ-033 SHALL take FILLER_WORD and CTRL_MAGIC defaults, the type encodings (TYPE_TLP, TYPE_TLP_LAST, TYPE_CFG, TYPE_CMD) and the FSM state enum from shared package pcileech_rx_pkg.
REQ-034 SHALL be a single module with no sub-module.

Verification
REQ-035 SHALL cover: wren pair 32'h12345678 then 32'h77000000 -> one cycle later tlp_valid=1, tlp_data=32'h12345678, tlp_last=0.
REQ-036 SHALL cover: 5x 32'h66665555, then pair 32'hAABBCCDD, 32'h77020000 -> only cfg_valid, cfg_data=64'h77020000_AABBCCDD, err_count=0.
REQ-037 SHALL cover: data 32'h1, bad ctrl 32'h00000002, then ctrl 32'h77030000 -> err_count=1, sync_lost=1, then cmd_data=64'h77030000_00000002, sync_lost=0.
REQ-038 SHALL cover: data 32'h5, rst_n low one cycle, then pair 32'h9, 32'h77010000 -> tlp_data=32'h9, tlp_last=1, no output for 32'h5.
REQ-039 SHALL cover: 70000 bad ctrl words with ERRCNT_W=16 -> err_count holds 16'hFFFF; without the macro, err_count=0 throughout.
